unary_to_binary_decoder: RTL and testbench
==========================================

// Module: unary_to_binary_decoder
// PURPOSE
//  Downstream stage of the unary adder: converts its unary output stream (a contiguous run of 1s) into a binary count.
//  Frame opens on a start pulse issued alongside the adder's operands; frame closes on the first cycle the stream is low.
//  The count is presented on a valid/ready result port, so the binary side of the MAC can stall without losing data.
//  Sticky error flags report protocol misuse and dropped results.
// PARAMETERS
//  BIN_BITS  4             operand width of the upstream unary stages
//  CNT_BITS  BIN_BITS+1    counter/result width; max representable run = 2**CNT_BITS-1 (31 at default)
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  reset_n    in   1         asynchronous, active-low reset
//  start      in   1         one-cycle pulse, same cycle the upstream adder inputs begin
//  in         in   1         unary stream from the adder output
//  out_data   out  CNT_BITS  decoded run length
//  out_valid  out  1         out_data holds an unconsumed result
//  out_ready  in   1         consumer accepts out_data when out_valid & out_ready
//  proto_err  out  1         sticky: protocol violation seen
//  overrun    out  1         sticky: result dropped because the result register was full
//  clear_err  in   1         synchronous clear of proto_err and overrun
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, count=0
//   - out_data=0, out_valid=0, proto_err=0, overrun=0
//  FSM: IDLE, COUNT.
//   - IDLE, start=1, in=1 -> COUNT; count<=1.
//   - IDLE, start=1, in=0 -> zero-length frame; closes immediately; result 0; stays IDLE.
//   - IDLE, start=0, in=1 -> ignored; proto_err<=1.
//   - COUNT, start=0, in=1 -> count<=count+1.
//   - COUNT, start=0, in=0 -> frame closes with result=count; count<=0; -> IDLE.
//   - COUNT, start=1 -> abort current frame (no result); proto_err<=1.
//     New frame begins exactly as from IDLE with start=1.
//  Frame close (result=R):
//   - out_data/out_valid update on the edge ending the closing cycle, so latency is 1 clk after the first low cycle.
//   - If out_valid=0, or out_valid=1 with out_ready=1 (same-cycle accept): out_data<=R, out_valid<=1.
//   - If out_valid=1 with out_ready=0: R is dropped, overrun<=1, and out_data is unchanged.
//  Handshake:
//   - Accept with no close in that cycle: out_valid<=0 and out_data holds its last value.
//   - out_data is stable while out_valid=1 and out_ready=0.
//  clear_err=1: both flags <=0 that cycle, unless a new error occurs the same cycle; a new error wins.
//  Count width: increments are evaluated at CNT_BITS; behaviour at all-ones is set by CONFIGURATION.
// CONFIGURATION
//  UNARY_DEC_SATURATE_EN defined:
//   - Counter saturates at 2**CNT_BITS-1.
//   - Any further 1 in the same frame sets overrun.
//  UNARY_DEC_SATURATE_EN undefined:
//   - Counter wraps modulo 2**CNT_BITS.
//   - No flag is raised; the caller guarantees run <= 2**CNT_BITS-1.
// STRUCTURE
//  Package unary_pkg:
//   - typedef enum logic {IDLE, COUNT} udec_state_t
//   - localparam/function for default CNT_BITS from BIN_BITS
//   - shared with the other unary stages
//  Sub-module unary_run_counter:
//   - CNT_BITS counter with clr/inc
//   - saturate/wrap controlled by UNARY_DEC_SATURATE_EN
//  Top holds the FSM, result register, handshake and flags.
// TESTING
//  1. start with in high 5 cycles then low, out_ready=1 -> out_data=5, out_valid=1 for exactly 1 cycle, flags 0.
//  2. start with in=0 -> out_data=0, out_valid=1 on next cycle.
//  3. Result 7 pending with out_ready=0; second frame of 3 closes -> out_data stays 7, overrun=1.
//     Then clear_err -> overrun=0.
//  4. Result 7 pending; frame of 3 closes in the same cycle out_ready=1 -> out_valid stays 1, out_data=3, no overrun.
//  5. start during a run of 4, then 2 more highs, then low -> proto_err=1, out_data=2.
//     Separately, in=1 while IDLE -> proto_err=1.
//  6. Run of 33 at CNT_BITS=5:
//     - With UNARY_DEC_SATURATE_EN: out_data=31, overrun=1.
//     - Without: out_data=1, overrun=0.
//     Also assert reset_n mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/unary_pkg.sv
// rtl/unary_pkg.sv - shared types and width helpers for the unary datapath stages
package unary_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } udec_state_t;

    localparam int UNARY_DEFAULT_BIN_BITS = 4;

    // One extra bit so a full-scale sum of two BIN_BITS operands still fits
    function automatic int cnt_bits_for(input int bin_bits);
        return bin_bits + 1;
    endfunction

endpackage

// File: rtl/unary_run_counter.sv
// rtl/unary_run_counter.sv - run-length counter; saturates under UNARY_DEC_SATURATE_EN, wraps otherwise
module unary_run_counter #(
    parameter int CNT_BITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [CNT_BITS-1:0] count_o,
    output logic                sat_hit_o
);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    // clr together with inc loads 1: a frame that opens on a high cycle counts it
    always_comb begin
        count_d   = count_q;
        sat_hit_o = 1'b0;
        if (clr_i) begin
            count_d = inc_i ? CNT_BITS'(1) : '0;
        end else if (inc_i) begin
`ifdef UNARY_DEC_SATURATE_EN
            if (&count_q) begin
                sat_hit_o = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
`else
            count_d = count_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/unary_to_binary_decoder.sv
// rtl/unary_to_binary_decoder.sv - unary run to binary count with valid/ready result and sticky flags
// Optional counter saturation: UNARY_DEC_SATURATE_EN
module unary_to_binary_decoder
    import unary_pkg::*;
#(
    parameter int BIN_BITS = UNARY_DEFAULT_BIN_BITS,
    parameter int CNT_BITS = cnt_bits_for(BIN_BITS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                in,
    output logic [CNT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                proto_err,
    output logic                overrun,
    input  logic                clear_err
);

    udec_state_t         state_q, state_d;
    logic [CNT_BITS-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                proto_err_q, proto_err_d;
    logic                overrun_q, overrun_d;

    logic                cnt_clr;
    logic                cnt_inc;
    logic [CNT_BITS-1:0] count;
    logic                sat_hit;
    logic                close;
    logic [CNT_BITS-1:0] result;
    logic                proto_set;
    logic                drop;

    unary_run_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_run_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .count_o   (count),
        .sat_hit_o (sat_hit)
    );

    // A start while counting aborts the frame and reopens it exactly as from IDLE
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        close     = 1'b0;
        result    = '0;
        proto_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    if (in) begin
                        cnt_inc = 1'b1;
                        state_d = COUNT;
                    end else begin
                        close = 1'b1;
                    end
                end else if (in) begin
                    proto_set = 1'b1;
                end
            end
            COUNT: begin
                if (start) begin
                    proto_set = 1'b1;
                    cnt_clr   = 1'b1;
                    if (in) begin
                        cnt_inc = 1'b1;
                    end else begin
                        close   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (in) begin
                    cnt_inc = 1'b1;
                end else begin
                    close   = 1'b1;
                    result  = count;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle accept frees the register, so a closing frame can replace it
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        drop        = 1'b0;
        if (close) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = result;
                out_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        proto_err_d = proto_set | (proto_err_q & ~clear_err);
        overrun_d   = drop | sat_hit | (overrun_q & ~clear_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            proto_err_q <= proto_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign proto_err = proto_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_unary_to_binary_decoder.sv
// tb/tb_unary_to_binary_decoder.sv - self-checking bench for unary_to_binary_decoder
module tb_unary_to_binary_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       in;
    logic [4:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       proto_err;
    logic       overrun;
    logic       clear_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        int         run;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[7];

    unary_to_binary_decoder #(
        .BIN_BITS (4),
        .CNT_BITS (5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in        (in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .proto_err (proto_err),
        .overrun   (overrun),
        .clear_err (clear_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every handshake must deliver the oldest outstanding result
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %0d, required no result", out_data);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %0d, required %0d", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic i);
        start = s;
        in    = i;
        @(posedge clk);
        #1;
        start     = 1'b0;
        in        = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic frame(input int run, input bit push);
        if (run == 0) begin
            if (push) exp_q.push_back(5'd0);
            drive(1'b1, 1'b0);
        end else begin
            drive(1'b1, 1'b1);
            repeat (run - 1) drive(1'b0, 1'b1);
            if (push) exp_q.push_back(5'(run));
            drive(1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [4:0] exp6_data;
        logic       exp6_ovr;
`ifdef UNARY_DEC_SATURATE_EN
        exp6_data = 5'd31;
        exp6_ovr  = 1'b1;
`else
        exp6_data = 5'd1;
        exp6_ovr  = 1'b0;
`endif
        vecs[0] = '{run: 0,  exp: 5'd0};
        vecs[1] = '{run: 1,  exp: 5'd1};
        vecs[2] = '{run: 2,  exp: 5'd2};
        vecs[3] = '{run: 9,  exp: 5'd9};
        vecs[4] = '{run: 16, exp: 5'd16};
        vecs[5] = '{run: 30, exp: 5'd30};
        vecs[6] = '{run: 31, exp: 5'd31};

        reset_n = 1'b0; start = 1'b0; in = 1'b0; out_ready = 1'b1; clear_err = 1'b0;
        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_proto", proto_err, 0);
        chk("reset_overrun", overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b0);

        // Run of 5, valid for exactly one cycle
        frame(5, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 5);
        chk("t1_proto", proto_err, 0);
        chk("t1_overrun", overrun, 0);
        drive(1'b0, 1'b0);
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_data_hold", out_data, 5);

        // Zero-length frame
        frame(0, 1);
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 0);
        drive(1'b0, 1'b0);

        // Table of run lengths with consumer always ready
        for (int k = 0; k < 7; k++) begin
            frame(vecs[k].run, 1);
            chk($sformatf("tab%0d_valid", k), out_valid, 1);
            chk($sformatf("tab%0d_data", k), out_data, vecs[k].exp);
            chk($sformatf("tab%0d_overrun", k), overrun, 0);
            drive(1'b0, 1'b0);
        end

        // Result pending, second frame dropped
        out_ready = 1'b0;
        frame(7, 1);
        chk("t3_pending", out_data, 7);
        frame(3, 0);
        chk("t3_data_held", out_data, 7);
        chk("t3_valid", out_valid, 1);
        chk("t3_overrun", overrun, 1);
        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        chk("t3_cleared", overrun, 0);

        // Close coincides with accept of pending 7
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        out_ready = 1'b1;
        exp_q.push_back(5'd3);
        drive(1'b0, 1'b0);
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 3);
        chk("t4_overrun", overrun, 0);
        drive(1'b0, 1'b0);

        // Restart mid-run
        drive(1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        chk("t5_proto", proto_err, 1);
        drive(1'b0, 1'b1);
        exp_q.push_back(5'd2);
        drive(1'b0, 1'b0);
        chk("t5_data", out_data, 2);
        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        chk("t5_cleared", proto_err, 0);
        drive(1'b0, 1'b1);
        chk("t5_idle_in", proto_err, 1);
        clear_err = 1'b1;
        drive(1'b0, 1'b1);
        chk("t5_new_err_wins", proto_err, 1);
        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        chk("t5_cleared2", proto_err, 0);

        // Run longer than the counter range
        exp_q.push_back(exp6_data);
        drive(1'b1, 1'b1);
        repeat (32) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        chk("t6_data", out_data, exp6_data);
        chk("t6_overrun", overrun, exp6_ovr);
        clear_err = 1'b1;
        drive(1'b0, 1'b0);

        // Asynchronous reset in the middle of a run
        out_ready = 1'b0;
        frame(4, 0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_proto", proto_err, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_proto", proto_err, 0);
        chk("t6_rst_overrun", overrun, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0);
        frame(2, 1);
        chk("t6_post_data", out_data, 2);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
